// File: rtl/memio_pkg.sv
// Shared types and constants for the CPU data-side memory/IO bus controller.
// Slot constants name the peripherals already wired to the IO window.
package memio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFFFC00;

  localparam int unsigned SLOT_TUBE     = 0;
  localparam int unsigned SLOT_KEYBOARD = 1;
  localparam int unsigned SLOT_TIMER    = 2;
  localparam int unsigned SLOT_PWM      = 3;
  localparam int unsigned SLOT_WATCHDOG = 5;
  localparam int unsigned SLOT_LED      = 6;
  localparam int unsigned SLOT_SWITCH   = 7;

  localparam logic [31:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/memio_slot_decoder.sv
// Combinational IO window decoder: 16-byte line address -> {hit, slot index, one-hot}.
// Takes the line address (address[31:4]) so it can be shared with the debug bus.
module memio_slot_decoder
  import memio_pkg::*;
#(
  parameter int unsigned N_SLOTS = 8,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic [27:0]        line_addr,
  output logic               hit,
  output logic [3:0]         slot,
  output logic [N_SLOTS-1:0] onehot
);

  localparam logic [27:0] BASE_LINE = IO_BASE[31:4];

  logic [27:0] offset;

  // Modular subtraction keeps a single comparator for both window ends.
  always_comb begin
    offset = line_addr - BASE_LINE;
    hit    = (offset < 28'(N_SLOTS));
    slot   = offset[3:0];
    onehot = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (hit && (slot == 4'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/memio_bus_ctrl.sv
// CPU data-side bus controller: combinational RAM path, registered IO transactions
// with per-slot ready handshake, CPU stall and timeout bus error.
module memio_bus_ctrl
  import memio_pkg::*;
#(
  parameter int unsigned N_SLOTS = 8,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int unsigned IO_DW   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                caddress,
  input  logic                       memread,
  input  logic                       memwrite,
  input  logic                       ioread,
  input  logic                       iowrite,
  input  logic                       sign_ext,
  input  logic [31:0]                mread_data,
  input  logic [31:0]                wdata,
  input  logic [N_SLOTS*IO_DW-1:0]   io_rdata,
  input  logic [N_SLOTS-1:0]         io_ready,
  output logic [31:0]                address,
  output logic [31:0]                write_data,
  output logic [31:0]                rdata,
  output logic [N_SLOTS-1:0]         io_cs,
  output logic                       io_rd,
  output logic                       io_wr,
  output logic                       stall,
  output logic                       bus_err,
  output logic [31:0]                err_addr
);

  localparam int unsigned   CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [3:0]         slot_q, slot_d;
  logic               wr_q, wr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_SLOTS-1:0] io_cs_q, io_cs_d;
  logic               io_rd_q, io_rd_d;
  logic               io_wr_q, io_wr_d;
  logic               bus_err_q, bus_err_d;

  logic               dec_hit;
  logic [3:0]         dec_slot;
  logic [N_SLOTS-1:0] dec_onehot;
  logic               io_req;
  logic               ready_sel;
  logic [IO_DW-1:0]   slot_data;
  logic [31:0]        slot_ext;

  memio_slot_decoder #(
    .N_SLOTS (N_SLOTS),
    .IO_BASE (IO_BASE)
  ) u_slot_decoder (
    .line_addr (caddress[31:4]),
    .hit       (dec_hit),
    .slot      (dec_slot),
    .onehot    (dec_onehot)
  );

  // Ready is masked by the registered select, so other slots' strobes are ignored.
  always_comb begin
    io_req    = ioread | iowrite;
    ready_sel = |(io_ready & io_cs_q);
    slot_data = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      if (slot_q == 4'(s)) slot_data = io_rdata[s*IO_DW +: IO_DW];
    end
    slot_ext             = (sign_ext && slot_data[IO_DW-1]) ? '1 : '0;
    slot_ext[IO_DW-1:0]  = slot_data;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    slot_d     = slot_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (io_req) begin
          addr_d = caddress;
          if (dec_hit) begin
            state_d = ACCESS;
            wdata_d = wdata;
            slot_d  = dec_slot;
            wr_d    = iowrite;
            cnt_d   = '0;
          end else begin
            state_d    = ERR;
            err_addr_d = caddress;
          end
        end
      end
      ACCESS: begin
        if (ready_sel) begin
          rdata_d = slot_ext;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ERR;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are computed from the next state so they line up with it as flops.
    io_cs_d   = '0;
    if (state_d == ACCESS) io_cs_d = (state_q == IDLE) ? dec_onehot : io_cs_q;
    io_rd_d   = (state_d == ACCESS) && !wr_d;
    io_wr_d   = (state_d == ACCESS) && wr_d;
    bus_err_d = (state_d == ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      slot_q     <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      io_cs_q    <= '0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      slot_q     <= slot_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      io_cs_q    <= io_cs_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    address    = (state_q == IDLE) ? caddress : addr_q;
    stall      = (state_q == ACCESS) || ((state_q == IDLE) && io_req);
    write_data = '0;
    if ((state_q == ACCESS) && wr_q) write_data = wdata_q;
    else if ((state_q == IDLE) && memwrite && !io_req) write_data = wdata;
    rdata = ERR_DATA;
    if (state_q == DONE) rdata = rdata_q;
    else if ((state_q == IDLE) && memread && !io_req) rdata = mread_data;
    io_cs    = io_cs_q;
    io_rd    = io_rd_q;
    io_wr    = io_wr_q;
    bus_err  = bus_err_q;
    err_addr = err_addr_q;
  end

endmodule

// File: tb/tb_memio_bus_ctrl.sv
// Scoreboard bench for memio_bus_ctrl: drivers push expected events, a negedge
// monitor checks each ACCESS cycle and pops on completion, error or RAM access.
module tb_memio_bus_ctrl;

  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned IO_DW   = 16;
  localparam int unsigned TIMEOUT = 15;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [31:0]              caddress;
  logic                     memread, memwrite, ioread, iowrite, sign_ext;
  logic [31:0]              mread_data, wdata;
  logic [N_SLOTS*IO_DW-1:0] io_rdata;
  logic [N_SLOTS-1:0]       io_ready;
  logic [31:0]              address, write_data, rdata, err_addr;
  logic [N_SLOTS-1:0]       io_cs;
  logic                     io_rd, io_wr, stall, bus_err;

  always #5 clock = ~clock;

  memio_bus_ctrl #(
    .N_SLOTS (N_SLOTS),
    .IO_BASE (32'hFFFFFC00),
    .IO_DW   (IO_DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .caddress   (caddress),
    .memread    (memread),
    .memwrite   (memwrite),
    .ioread     (ioread),
    .iowrite    (iowrite),
    .sign_ext   (sign_ext),
    .mread_data (mread_data),
    .wdata      (wdata),
    .io_rdata   (io_rdata),
    .io_ready   (io_ready),
    .address    (address),
    .write_data (write_data),
    .rdata      (rdata),
    .io_cs      (io_cs),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .stall      (stall),
    .bus_err    (bus_err),
    .err_addr   (err_addr)
  );

  typedef enum int {K_MEM, K_DONE, K_ERR, K_ABORT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  cs;
    logic        rd;
    logic        wr;
    int          n_acc;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc      = 0;
  logic prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input kind_e k, input logic [31:0] rd_v, input logic [31:0] a,
                              input logic [31:0] wd, input logic [7:0] cs, input logic rd,
                              input logic wr, input int n, input logic chk);
    exp_t r;
    r.kind = k; r.rdata = rd_v; r.addr = a; r.wdata = wd; r.cs = cs;
    r.rd = rd; r.wr = wr; r.n_acc = n; r.chk_rd = chk;
    return r;
  endfunction

  // Monitor
  always @(negedge clock) begin
    if (reset) begin
      if (io_cs != '0) acc++;
      if (sb.size() > 0 && sb[0].kind == K_ABORT) begin
        mon_e = sb.pop_front();
        check("abort_access_cycles", acc, mon_e.n_acc);
      end
      acc = 0;
      prev_stall = 1'b0;
    end else begin
      if (io_cs != '0) begin
        acc++;
        if (sb.size() == 0) check("unexpected_io_cs", 32'(io_cs), 32'h0);
        else begin
          check("access_io_cs", 32'(io_cs), 32'(sb[0].cs));
          check("access_io_rd", 32'(io_rd), 32'(sb[0].rd));
          check("access_io_wr", 32'(io_wr), 32'(sb[0].wr));
          check("access_write_data", write_data, sb[0].wdata);
          check("access_stall", 32'(stall), 32'h1);
        end
      end else if (bus_err) begin
        if (sb.size() == 0) check("unexpected_bus_err", 32'(bus_err), 32'h0);
        else begin
          mon_e = sb.pop_front();
          check("err_event_kind", 32'(K_ERR), 32'(mon_e.kind));
          check("err_addr", err_addr, mon_e.addr);
          check("err_rdata", rdata, 32'h0);
          check("err_stall", 32'(stall), 32'h0);
          check("err_access_cycles", acc, mon_e.n_acc);
        end
        acc = 0;
      end else if (prev_stall && !stall) begin
        if (sb.size() == 0) check("unexpected_stall_release", 32'(stall), 32'h1);
        else begin
          mon_e = sb.pop_front();
          check("done_event_kind", 32'(K_DONE), 32'(mon_e.kind));
          check("done_rdata", rdata, mon_e.rdata);
          check("done_access_cycles", acc, mon_e.n_acc);
        end
        acc = 0;
      end else if ((memread || memwrite) && !ioread && !iowrite && !stall && !prev_stall) begin
        if (sb.size() == 0) check("unexpected_mem_op", 32'(memread | memwrite), 32'h0);
        else begin
          mon_e = sb.pop_front();
          check("mem_event_kind", 32'(K_MEM), 32'(mon_e.kind));
          check("mem_address", address, mon_e.addr);
          check("mem_write_data", write_data, mon_e.wdata);
          if (mon_e.chk_rd) check("mem_rdata", rdata, mon_e.rdata);
        end
      end
      prev_stall = stall;
    end
  end

  task automatic mem_op(input logic rd, input logic [31:0] a, input logic [31:0] md,
                        input logic [31:0] wd, input exp_t e);
    sb.push_back(e);
    caddress = a; memread = rd; memwrite = !rd; mread_data = md; wdata = wd;
    @(posedge clock); #1;
    memread = 1'b0; memwrite = 1'b0; wdata = '0;
  endtask

  task automatic io_op(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int unsigned slot, input int ready_at, input logic [15:0] d,
                       input logic sx, input exp_t e);
    sb.push_back(e);
    caddress = a; ioread = !wr; iowrite = wr; wdata = wd; sign_ext = sx;
    io_rdata = '0;
    io_rdata[slot*IO_DW +: IO_DW] = d;
    io_ready = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      io_ready = '0;
      if (c == ready_at) io_ready[slot] = 1'b1;
      else if (c > 0 && c < ready_at) io_ready = ~(8'b1 << slot);
      @(negedge clock);
      if (c > 0 && !stall) break;
      if (c == 39) check("txn_stall_timeout", 32'(stall), 32'h0);
    end
    @(posedge clock); #1;
    ioread = 1'b0; iowrite = 1'b0; io_ready = '0; wdata = '0;
  endtask

  initial begin
    reset = 1'b1; caddress = '0; memread = 0; memwrite = 0; ioread = 0; iowrite = 0;
    sign_ext = 0; mread_data = '0; wdata = '0; io_rdata = '0; io_ready = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_io_cs", 32'(io_cs), 32'h0);
    check("rst_io_rd", 32'(io_rd), 32'h0);
    check("rst_io_wr", 32'(io_wr), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_write_data", write_data, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    mem_op(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,
           mk(K_MEM, 32'h1234_5678, 32'h0000_0100, 32'h0, 8'h00, 0, 0, 0, 1'b1));
    mem_op(1'b0, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF,
           mk(K_MEM, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 8'h00, 0, 0, 0, 1'b0));

    io_op(1'b0, 32'hFFFF_FC20, 32'h0, 2, 3, 16'h8001, 1'b1,
          mk(K_DONE, 32'hFFFF_8001, 32'h0, 32'h0, 8'b0000_0100, 1, 0, 3, 1'b1));
    io_op(1'b0, 32'hFFFF_FC20, 32'h0, 2, 3, 16'h8001, 1'b0,
          mk(K_DONE, 32'h0000_8001, 32'h0, 32'h0, 8'b0000_0100, 1, 0, 3, 1'b1));
    io_op(1'b1, 32'hFFFF_FC60, 32'h0000_ABCD, 6, 1, 16'h0000, 1'b0,
          mk(K_DONE, 32'h0, 32'h0, 32'h0000_ABCD, 8'b0100_0000, 0, 1, 1, 1'b1));
    io_op(1'b0, 32'hFFFF_FC30, 32'h0, 3, -1, 16'h5555, 1'b0,
          mk(K_ERR, 32'h0, 32'hFFFF_FC30, 32'h0, 8'b0000_1000, 1, 0, TIMEOUT, 1'b1));
    io_op(1'b1, 32'hFFFF_FD10, 32'h0000_1111, 0, -1, 16'h0, 1'b0,
          mk(K_ERR, 32'h0, 32'hFFFF_FD10, 32'h0, 8'h00, 0, 1, 0, 1'b1));

    // Reset during the second ACCESS cycle
    sb.push_back(mk(K_ABORT, 32'h0, 32'h0, 32'h0, 8'b0010_0000, 1, 0, 2, 1'b0));
    caddress = 32'hFFFF_FC50; ioread = 1'b1; io_rdata = '0; io_ready = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; ioread = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_io_cs", 32'(io_cs), 32'h0);
    check("abort_io_rd", 32'(io_rd), 32'h0);
    check("abort_bus_err", 32'(bus_err), 32'h0);
    check("abort_stall", 32'(stall), 32'h0);
    check("abort_err_addr", err_addr, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    @(posedge clock); #1;

    // Ready arrives in the same cycle the timeout would fire
    io_op(1'b0, 32'hFFFF_FC70, 32'h0, 7, TIMEOUT, 16'hC3A5, 1'b1,
          mk(K_DONE, 32'hFFFF_C3A5, 32'h0, 32'h0, 8'b1000_0000, 1, 0, TIMEOUT, 1'b1));

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
